// File: rtl/mem_burst.sv
// Burst-capable scratch RAM: INCR/WRAP bursts with byte strobes, read back-pressure,
// range/alignment error detection and a one-cycle completion response.
module mem_burst #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int MAX_LEN    = 16,
    parameter int LEN_WIDTH  = $clog2(MAX_LEN)
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  wrap,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    wstrb,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rlast,
    output logic                  done,
    output logic                  err
);

    localparam int STRB_WIDTH = WIDTH / 8;
    localparam int EXT_WIDTH  = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);
    localparam logic [EXT_WIDTH-1:0]  LAST_ADDR = EXT_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] cur_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  beat_q;
    logic                  wrap_q;
    logic                  err_q;

    logic                  cmd_fire;
    logic                  w_fire;
    logic                  r_fire;
    logic                  last_beat;
    logic                  cmd_err;
    logic                  incr_err;
    logic                  wrap_err;
    logic [EXT_WIDTH-1:0]  incr_end;
    logic [ADDR_WIDTH-1:0] len_in_ext;
    logic [ADDR_WIDTH-1:0] len_q_ext;
    logic [ADDR_WIDTH-1:0] cur_inc;
    logic [ADDR_WIDTH-1:0] cur_adv;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign w_fire    = (state == WRITE) && wvalid && wready;
    assign r_fire    = (state == READ) && rvalid && rready;
    assign last_beat = (beat_q == len_q);

    // Range check is done one bit wider so a burst running past the top cannot alias to a low address.
    assign len_in_ext = ADDR_WIDTH'(len);
    assign incr_end   = {1'b0, addr} + EXT_WIDTH'(len);
    assign incr_err   = (incr_end > LAST_ADDR);
    assign wrap_err   = (((len + LEN_ONE) & len) != '0) || ((addr & len_in_ext) != '0);
    assign cmd_err    = wrap ? wrap_err : incr_err;

    // A WRAP burst keeps the base's upper bits and lets only the low len bits roll over.
    assign len_q_ext = ADDR_WIDTH'(len_q);
    assign cur_inc   = cur_q + ADDR_ONE;
    assign cur_adv   = wrap_q ? ((base_q & ~len_q_ext) | (cur_inc & len_q_ext)) : cur_inc;

    always_ff @(posedge clk) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every variable written here gets a default first, so no latch is inferred on any path.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    if (cmd_err) begin
                        state_next = RESP;
                    end else if (wr_rd) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            WRITE: begin
                if (w_fire && last_beat) begin
                    state_next = RESP;
                end
            end
            READ: begin
                if (r_fire && last_beat) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (res) begin
            cmd_ready <= 1'b0;
            wready    <= 1'b0;
            rvalid    <= 1'b0;
            rlast     <= 1'b0;
            rdata     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            base_q    <= '0;
            cur_q     <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cmd_ready <= (state_next == IDLE);
            wready    <= (state_next == WRITE);
            done      <= (state_next == RESP);
            err       <= (state_next == RESP) && (cmd_fire ? cmd_err : err_q);

            if (cmd_fire) begin
                base_q <= addr;
                cur_q  <= addr;
                len_q  <= len;
                wrap_q <= wrap;
                beat_q <= '0;
                err_q  <= cmd_err;
                if (!wr_rd && !cmd_err) begin
                    rvalid <= 1'b1;
                    rdata  <= mem[addr];
                    rlast  <= (len == '0);
                end
            end else if (w_fire) begin
                cur_q  <= cur_adv;
                beat_q <= beat_q + LEN_ONE;
            end else if (r_fire) begin
                if (last_beat) begin
                    rvalid <= 1'b0;
                    rlast  <= 1'b0;
                end else begin
                    cur_q  <= cur_adv;
                    beat_q <= beat_q + LEN_ONE;
                    rdata  <= mem[cur_adv];
                    rlast  <= ((beat_q + LEN_ONE) == len_q);
                end
            end
        end
    end

    // NOTE: the whole array is cleared on reset, so it maps to flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (w_fire) begin
            for (int k = 0; k < STRB_WIDTH; k++) begin
                if (wstrb[k]) begin
                    mem[cur_q][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

endmodule
